// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the load/store memory sequencer.
// Size codes, FSM states and the latched request bundle.
package mem_access_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RMW_RD,
        RMW_WR,
        WRITE,
        RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Size 11 is never a legal access, so it is folded in here.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        return (size == SIZE_HALF && lo[0])
            || (size == SIZE_WORD && lo != 2'b00)
            || (size == 2'b11);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Word-wide data memory bus with a variable-latency ready handshake.
// master = sequencer side, slave = memory side.
interface mem_access_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/mem_access_ctrl_lane_unit.sv
// Little-endian lane merge for sub-word stores and lane extract
// with sign/zero extension for sub-word loads.
module mem_access_ctrl_lane_unit
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  b;
    logic [15:0] h;

    assign bsh = {addr_lo, 3'b000};
    assign hsh = {addr_lo[1], 4'b0000};
    assign b   = rdata[bsh +: 8];
    assign h   = rdata[hsh +: 16];

    always_comb begin
        merged    = rdata;
        extracted = rdata;
        unique case (1'b1)
            size == SIZE_BYTE: begin
                merged[bsh +: 8] = wdata[7:0];
                extracted = {{24{b[7] & ~uns}}, b};
            end
            size == SIZE_HALF: begin
                merged[hsh +: 16] = wdata[15:0];
                extracted = {{16{h[15] & ~uns}}, h};
            end
            default: begin
                merged    = wdata;
                extracted = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer: RMW for sub-word stores, lane
// extract for loads, misalignment and watchdog errors.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [1:0]         cpu_size,
    input  logic               cpu_unsigned,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic               cpu_ack,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_err,
    output logic               busy,
    mem_access_ctrl_if.master  mem
);

    localparam logic [31:0] TLIM = 32'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] tcnt_q, tcnt_d;

    logic [31:0] merged;
    logic [31:0] extracted;
    logic        tmo;
    logic        in_mem;
    logic        mis;
    logic        go_rd, go_wr, go_rmw;

    mem_access_ctrl_lane_unit u_lane (
        .addr_lo   (req_q.addr[1:0]),
        .size      (req_q.size),
        .uns       (req_q.uns),
        .wdata     (req_q.wdata),
        .rdata     (mem.mem_rdata),
        .merged    (merged),
        .extracted (extracted)
    );

    assign in_mem = (state_q == READ) || (state_q == RMW_RD)
                 || (state_q == RMW_WR) || (state_q == WRITE);

    // Fires on the last allowed waiting cycle, so mem_req is held for
    // exactly TIMEOUT_CYCLES cycles before being dropped.
    assign tmo = (TLIM != 32'd0) && (tcnt_q == TLIM - 32'd1);

    assign mis    = misaligned(cpu_size, cpu_addr[1:0]);
    assign go_rd  = !mis && !cpu_we;
    assign go_wr  = !mis && cpu_we && (cpu_size == SIZE_WORD);
    assign go_rmw = !mis && cpu_we && (cpu_size != SIZE_WORD);

    assign mem.mem_req   = in_mem;
    assign mem.mem_we    = (state_q == WRITE) || (state_q == RMW_WR);
    assign mem.mem_addr  = {req_q.addr[31:2], 2'b00};
    assign mem.mem_wdata = mwdata_q;

    assign busy      = (state_q != IDLE);
    assign cpu_ack   = (state_q == RESP);
    assign cpu_rdata = cpu_ack ? rdata_q : 32'd0;
    assign cpu_err   = cpu_ack & err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= '0;
            mwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            mwdata_q <= mwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tcnt_q   <= tcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        mwdata_d = mwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tcnt_d   = tcnt_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    req_d.we    = cpu_we;
                    req_d.size  = cpu_size;
                    req_d.uns   = cpu_unsigned;
                    req_d.addr  = cpu_addr;
                    req_d.wdata = cpu_wdata;
                    mwdata_d    = cpu_wdata;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    tcnt_d      = '0;
                    unique case (1'b1)
                        mis: begin
                            err_d   = 1'b1;
                            state_d = RESP;
                        end
                        go_rd:  state_d = READ;
                        go_wr:  state_d = WRITE;
                        go_rmw: state_d = RMW_RD;
                        default: state_d = IDLE;
                    endcase
                end
            end
            READ, RMW_RD, RMW_WR, WRITE: begin
                if (mem.mem_ready) begin
                    tcnt_d = '0;
                    if (state_q == READ) begin
                        rdata_d = extracted;
                        state_d = RESP;
                    end else if (state_q == RMW_RD) begin
                        mwdata_d = merged;
                        state_d  = RMW_WR;
                    end else begin
                        state_d = RESP;
                    end
                end else if (tmo) begin
                    // A timed-out RMW read never reaches the write.
                    tcnt_d  = '0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule
